// File: rtl/keypad_scan_controller_if.sv
// Key handoff channel: the controller presents keyCode/keyValid, the consumer answers with keyReady.
interface keypad_scan_controller_if;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyReady;

  modport master (output keyCode, output keyValid, input keyReady);
  modport slave  (input keyCode, input keyValid, output keyReady);
endinterface

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: column rotation, row debounce, ghost rejection and a valid/ready key handoff.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_controller #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic                            clock_Value,
  input  logic                            reset_n,
  input  logic [3:0]                      rowValue,
  output logic [3:0]                      colValue,
  output logic                            scanActive,
  keypad_scan_controller_if.master        key_if
);

  if (SCAN_DIV < 1 || SCAN_DIV > 32'hFFFFF || DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES > 32'hFFFFF || REPEAT_CYCLES < 1 || REPEAT_CYCLES > 32'hFFFFFF) begin : g_bad_params
    $error("keypad_scan_controller: parameter out of legal range");
  end

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);
  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic [19:0] div_q, div_d;
  logic [19:0] deb_q, deb_d;
  logic        single_row;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);
  logic [23:0] rep_q, rep_d;
  logic        arm_q, arm_d;
`endif

  // Position of the (first) low bit in an active-low vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign single_row = ($countones(~pat_q) == 1);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    col_d   = col_q;
    code_d  = code_q;
    valid_d = valid_q;
    div_d   = div_q;
    deb_d   = deb_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    arm_d   = arm_q;
`endif
    case (state_q)
      SCAN: begin
        if (sync2_q != 4'hF) begin
          pat_d   = sync2_q;
          deb_d   = '0;
          state_d = DEBOUNCE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          col_d = {col_q[0], col_q[3:1]};
        end else begin
          div_d = div_q + 20'd1;
        end
      end
      DEBOUNCE: begin
        if (sync2_q != pat_q) begin
          state_d = SCAN;
          deb_d   = '0;
          div_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          deb_d = '0;
          if (single_row) begin
            code_d  = {low_idx(pat_q), low_idx(col_q)};
            valid_d = 1'b1;
            state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
            arm_d   = 1'b1;
`endif
          end else begin
            state_d = RELEASE;
`ifdef KEYPAD_REPEAT_EN
            arm_d   = 1'b0;
`endif
          end
        end else begin
          deb_d = deb_q + 20'd1;
        end
      end
      PRESSED: begin
        if (key_if.keyReady) begin
          valid_d = 1'b0;
          deb_d   = '0;
          state_d = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        // Hold time keeps accruing while the consumer stalls; saturate at the repeat point.
        if (sync2_q != pat_q) arm_d = 1'b0;
        if (rep_q != REP_LAST) rep_d = rep_q + 24'd1;
`endif
      end
      RELEASE: begin
        if (sync2_q != 4'hF) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          div_d   = '0;
          state_d = SCAN;
        end else begin
          deb_d = deb_q + 20'd1;
        end
`ifdef KEYPAD_REPEAT_EN
        if (arm_q && sync2_q == pat_q) begin
          if (rep_q == REP_LAST) begin
            rep_d   = '0;
            valid_d = 1'b1;
            state_d = PRESSED;
          end else begin
            rep_d = rep_q + 24'd1;
          end
        end else begin
          arm_d = 1'b0;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
    active_d = (state_d == SCAN);
  end

  always_ff @(posedge clock_Value) begin
    if (!reset_n) begin
      state_q  <= SCAN;
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      pat_q    <= 4'hF;
      col_q    <= 4'b1110;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
      active_q <= 1'b1;
      div_q    <= '0;
      deb_q    <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= '0;
      arm_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync1_q  <= rowValue;
      sync2_q  <= sync1_q;
      pat_q    <= pat_d;
      col_q    <= col_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      div_q    <= div_d;
      deb_q    <= deb_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q    <= rep_d;
      arm_q    <= arm_d;
`endif
    end
  end

  assign colValue        = col_q;
  assign scanActive      = active_q;
  assign key_if.keyCode  = code_q;
  assign key_if.keyValid = valid_q;

endmodule
